// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, FSM state type and error read-data pattern
// for the wait-state memory slave.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [31:0] BAD_DATA = 32'hBADDBEEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_lane_dec.sv
// Decodes transfer size and low address bits into little-endian byte
// strobes plus a misalignment flag; oversize requests decode as words.
module ahbl_lane_dec
    import ahbl_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);

    always_comb begin
        strb_o     = 4'b1111;
        misalign_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
            HSIZE_HALF: begin
                strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_i[0];
            end
            HSIZE_WORD: misalign_o = (addr_i != 2'b00);
            default:    misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahbl_wait_mem.sv
// AHB-Lite word-array slave inserting WAIT_STATES low-HREADYOUT cycles per
// transfer. Define ERR_RESP_EN to answer misaligned/oversize accesses with ERROR.
module ahbl_wait_mem
    import ahbl_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [31:0]   mem_q [2**AW];
    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [3:0]    strb_q;

    logic [3:0] lane_strb;
    logic       lane_misalign;
    logic       accept;
    logic       err;
    logic       commit;

    ahbl_lane_dec u_lane_dec (
        .size_i     (HSIZE),
        .addr_i     (HADDR[1:0]),
        .strb_o     (lane_strb),
        .misalign_o (lane_misalign)
    );

    // A new address phase can only overlap an idle bus or the final data cycle.
    assign accept = ((state_q == ST_IDLE) || (state_q == ST_LAST)) &&
                    HSEL && htrans_active(HTRANS) && HREADY;

`ifdef ERR_RESP_EN
    assign err = lane_misalign;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
        end else if (accept) begin
            cnt_q   <= WS;
            write_q <= HWRITE && !err;
            if (err)
                state_q <= ST_ERR1;
            else if (WS != 4'd0)
                state_q <= ST_WAIT;
            else
                state_q <= ST_LAST;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1)
                        state_q <= ST_LAST;
                end
                ST_ERR1: state_q <= ST_ERR2;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_q <= HADDR[AW+1:2];
            strb_q <= lane_strb;
        end
    end

    // A reset landing on the final cycle drops the pending write.
    assign commit = (state_q == ST_LAST) && write_q && !HRESET;

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i])
                    mem_q[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);

    always_comb begin
        case (state_q)
            ST_LAST:          HRDATA = mem_q[addr_q];
            ST_ERR1, ST_ERR2: HRDATA = BAD_DATA;
            default:          HRDATA = 32'h0;
        endcase
    end

`ifdef ERR_RESP_EN
    assign HRESP = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign HRESP = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{HADDR[31:AW+2], lane_misalign};

endmodule

// File: doc/ahbl_wait_mem.md
# ahbl_wait_mem

AHB-Lite memory slave with a programmable number of wait states. It sits on one slave port of the AHB-Lite bus splitter, behind one 256 MB page, and stores data in an internal word array. It accepts pipelined transfers of byte, halfword and word size. It drives HREADYOUT low for a fixed number of cycles per transfer to model slow memory.

## Interface
- AW, 10: word-address bits; array depth is 2^AW words, and HADDR[AW+1:2] indexes it.
- WAIT_STATES, 1: low-HREADYOUT cycles per transfer, range 0..15.
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select from the splitter decoder.
- HADDR  in  32  address; only [AW+1:0] are used.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ or SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, returned through the splitter mux.
- HREADYOUT  out  1  slave ready; reset value 1.
- HRDATA  out  32  read data; reset value 32'h0.
- HRESP  out  1  0 = OKAY, 1 = ERROR; reset value 0.

## Operation
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. On acceptance, the block latches the address, HWRITE and HSIZE, and loads the wait counter with WAIT_STATES.
- States:
  - IDLE: no data phase pending.
  - WAIT: counter > 0; HREADYOUT=0; counter decrements each cycle.
  - LAST: HREADYOUT=1; the transfer completes at this clock edge.
  - ERR1, ERR2: error response, present only with ERR_RESP_EN.
- Transitions:
  - IDLE→WAIT on acceptance when WAIT_STATES>0; IDLE→LAST when WAIT_STATES=0.
  - WAIT→LAST when the counter reaches 1.
  - LAST→WAIT or LAST on a new acceptance in the same cycle (back-to-back pipelining); otherwise LAST→IDLE.
- Writes commit at the LAST-cycle clock edge.
  - Byte lanes are little-endian, selected by the latched HSIZE and addr[1:0].
  - Byte: lane addr[1:0]. Halfword: lanes {addr[1],0}+0..1. Word: all lanes.
  - Unselected lanes keep their contents.
- Reads: in LAST, HRDATA = mem[addr_q], all 32 bits regardless of size. HRDATA = 0 in every other cycle.
- IDLE/BUSY transfers and cycles with HSEL=0 are not accepted. They get a zero-wait OKAY: HREADYOUT stays 1.
- Read-after-write to the same word, back-to-back: the read returns the new data, because the write commits before the read's LAST cycle.
- Reset mid-transfer: the FSM returns to IDLE and a pending write is dropped. Memory contents are never reset.
- Address bits above AW+1 are ignored, so the array aliases within the page.

## Timing
- Address phase in cycle N → LAST (HREADYOUT=1, read data valid) in cycle N+1+WAIT_STATES.
- Sustained throughput is one transfer per WAIT_STATES+1 cycles.
- HRESP=0 in every cycle unless ERR_RESP_EN is defined.
- HREADYOUT is combinational from the FSM state only; it never depends on same-cycle inputs.

## Configuration
- ERR_RESP_EN defined:
  - Errors are misaligned accesses (halfword with addr[0]=1; word with addr[1:0]≠0) and HSIZE>2.
  - An erroring transfer skips the wait states and gets the two-cycle AHB ERROR response: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
  - No memory write occurs. HRDATA = 32'hBADDBEEF during ERR1 and ERR2.
  - A transfer presented during ERR2 is not accepted, because HREADY is low in ERR1 and the master cancels its transfer.
- ERR_RESP_EN undefined:
  - Low address bits are masked down to the access size's alignment.
  - HSIZE>2 is treated as a word access.
  - HRESP is tied to 0.

## Structure
- Package ahbl_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ) and HSIZE codes.
  - The FSM state enum.
  - The bad-data constant 32'hBADDBEEF.
- One sub-module, ahbl_lane_dec: combinational decode of (size, addr[1:0]) into a 4-bit byte strobe and a misalignment flag.

## Test plan
- Reset: assert HRESET for 2 cycles mid-write to 0x10 with WAIT_STATES=2 → HREADYOUT=1, HRESP=0, HRDATA=0; word 0x10 is unchanged.
- WAIT_STATES=2: word write 0xCAFEF00D at 0x8, then read 0x8 → each data phase holds HREADYOUT low for exactly 2 cycles; the read returns 0xCAFEF00D in cycle N+3.
- Byte lanes: word write 0x11223344 at 0x4, then byte write 0xAA at 0x6 and halfword write 0xBBCC at 0x4 → word read at 0x4 returns 0x11AABBCC.
- WAIT_STATES=0, back-to-back: write 0x5 to 0x0, read 0x0, then IDLE → zero-wait; the read returns 0x5; IDLE gets OKAY and HRDATA=0.
- HSEL=0 with HTRANS=NONSEQ write → no state change and memory unchanged.
- ERR_RESP_EN: word read at 0x2 → one cycle with HREADYOUT=0, HRESP=1, then one with HREADYOUT=1, HRESP=1; HRDATA=0xBADDBEEF. Word write at 0x2 → memory unchanged.
